// File: rtl/input_ram_ctrl.sv
`default_nettype none
// input_ram_ctrl: loads one input vector from a valid/ready stream into the input RAM,
// then replays it cfg_passes times to the MAC stage with RAM-aligned read flags.
module input_ram_ctrl #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 4,
  parameter int P_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH:0]   cfg_len,
  input  logic [P_WIDTH-1:0] cfg_passes,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               in_ready,
  input  logic               mac_ready,
  output logic               ram_w_en,
  output logic [A_WIDTH-1:0] ram_w_addr,
  output logic [D_WIDTH-1:0] ram_w_data,
  output logic [A_WIDTH-1:0] ram_r_addr,
  output logic               rd_valid,
  output logic               rd_first,
  output logic               rd_last,
  output logic [P_WIDTH-1:0] pass_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [A_WIDTH:0]   MAX_LEN = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [A_WIDTH:0]   ONE_A   = {{A_WIDTH{1'b0}}, 1'b1};
  localparam logic [P_WIDTH-1:0] ONE_P   = {{(P_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_READ = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [A_WIDTH:0]   len;
  logic [P_WIDTH-1:0] passes;
  logic [A_WIDTH:0]   w_ptr;
  logic [A_WIDTH:0]   r_ptr;
  logic [P_WIDTH-1:0] pass_cnt;

  logic               accept;
  logic               issue;
  logic               r_last;
  logic               p_last;
  logic [A_WIDTH:0]   len_eff;
  logic [P_WIDTH-1:0] passes_eff;

  assign accept     = (state == S_IDLE) && start && (cfg_len != '0);
  assign issue      = (state == S_READ) && mac_ready;
  assign r_last     = (r_ptr == len - ONE_A);
  assign p_last     = (pass_cnt == passes - ONE_P);
  assign len_eff    = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
  assign passes_eff = (cfg_passes == '0) ? ONE_P : cfg_passes;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_nx = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (w_ptr == len - ONE_A)) state_nx = S_READ;
      end
      S_READ: begin
        if (issue && r_last && p_last) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Write port is purely combinational off the handshake; data is gated so idle outputs read 0.
  assign ram_w_en   = in_valid & in_ready;
  assign ram_w_addr = w_ptr[A_WIDTH-1:0];
  assign ram_w_data = in_ready ? in_data : '0;
  assign ram_r_addr = r_ptr[A_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      len      <= '0;
      passes   <= '0;
      w_ptr    <= '0;
      r_ptr    <= '0;
      pass_cnt <= '0;
      rd_valid <= 1'b0;
      rd_first <= 1'b0;
      rd_last  <= 1'b0;
      pass_idx <= '0;
    end else begin
      rd_valid <= issue;
      rd_first <= issue && (r_ptr == '0);
      rd_last  <= issue && r_last;
      pass_idx <= pass_cnt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            len      <= len_eff;
            passes   <= passes_eff;
            w_ptr    <= '0;
            r_ptr    <= '0;
            pass_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) w_ptr <= w_ptr + ONE_A;
        end
        S_READ: begin
          // The final issue wraps the address but leaves pass_cnt on the last pass.
          if (mac_ready) begin
            if (r_last) begin
              r_ptr <= '0;
              if (!p_last) pass_cnt <= pass_cnt + ONE_P;
            end else begin
              r_ptr <= r_ptr + ONE_A;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/input_ram_ctrl.md
# input_ram_ctrl

Sequencer for one single-port-write / registered-read input RAM (16 × 16-bit default) in the DNN datapath. It loads a layer's input vector from an upstream valid/ready stream into the RAM. It then replays the vector `cfg_passes` times, once per neuron, to the MAC stage, issuing read addresses and flagging the data words the RAM returns one cycle later. It is the only writer and reader of that RAM.

## Interface
- `D_WIDTH`, 16: data word width; matches the RAM.
- `A_WIDTH`, 4: RAM address width; depth is 2**A_WIDTH.
- `P_WIDTH`, 8: width of the pass (neuron) counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `cfg_len`  in  A_WIDTH+1  words per vector; sampled on accepted `start`.
- `cfg_passes`  in  P_WIDTH  number of read sweeps; sampled on accepted `start`.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  D_WIDTH  upstream word.
- `in_ready`  out  1  controller accepts a word this cycle.
- `mac_ready`  in  1  MAC stage can take a word next cycle; gates read issue.
- `ram_w_en`  out  1  RAM write enable.
- `ram_w_addr`  out  A_WIDTH  RAM write address.
- `ram_w_data`  out  D_WIDTH  RAM write data.
- `ram_r_addr`  out  A_WIDTH  RAM read address (the RAM registers it).
- `rd_valid`  out  1  RAM `data_out` is valid this cycle.
- `rd_first`  out  1  with `rd_valid`: word 0 of a pass.
- `rd_last`  out  1  with `rd_valid`: last word of a pass.
- `pass_idx`  out  P_WIDTH  pass number of the word flagged by `rd_valid`.
- `busy`  out  1  high in LOAD, READ and DONE.
- `done`  out  1  one-cycle pulse in the DONE state.

## Operation
- States: IDLE, LOAD, READ, DONE.
- Transitions:
  - IDLE→LOAD on `start` with `cfg_len` ≠ 0.
  - LOAD→READ after write number `len`.
  - READ→DONE after the final address of the final pass is issued.
  - DONE→IDLE unconditionally.
- Config rules:
  - `start` with `cfg_len`=0 is ignored: stay in IDLE, no `done`.
  - `cfg_len` > 2**A_WIDTH is clamped to 2**A_WIDTH.
  - `cfg_passes`=0 is treated as 1.
  - `start` outside IDLE is ignored.
- LOAD:
  - `in_ready`=1.
  - `ram_w_en` = `in_valid & in_ready`, combinational.
  - `ram_w_addr` = write pointer, starting at 0.
  - `ram_w_data` = `in_data`.
  - The pointer increments on each handshake. On handshake number `len` the state moves to READ, and `in_ready` is 0 from the next cycle on.
- READ:
  - `ram_r_addr` = read pointer, registered and starting at 0.
  - An issue happens in any READ cycle with `mac_ready`=1. The pointer then advances. At `len`-1 it wraps to 0 and the pass counter increments.
  - `mac_ready`=0 holds the pointer. The RAM re-reads the same address, but `rd_valid` is not raised for it.
  - `rd_valid`, `rd_first`, `rd_last` and `pass_idx` are registered copies of the issue flag, pointer==0, pointer==`len`-1 and the pass counter. They line up with RAM `data_out`.
- DONE: the last word's `rd_valid`/`rd_last` fall in this cycle, together with `done`=1.
- `cfg_len`=1: every issue is both first and last; `ram_r_addr` stays 0.
- Reset: every output is 0 in the cycle after `rst` is sampled low, and state is IDLE. This also applies mid-LOAD or mid-READ. RAM contents are not cleared, and a partial vector is discarded logically.
- Arithmetic: the pointers are A_WIDTH+1 bits internally so that a length of 2**A_WIDTH counts correctly. Only the low A_WIDTH bits drive the RAM.

## Timing
- `start` is accepted at edge k. `in_ready`=1 from cycle k+1.
- With `in_valid` held high, `len` words are written in `len` cycles.
- The first read address is issued in the cycle after the last write. The RAM latches that write at the same edge, so read-after-write is safe.
- Read latency: address issued in cycle t → `rd_valid` and data in cycle t+1.
- With `mac_ready` held high, all passes stream back-to-back: `len`×`passes` consecutive `rd_valid` cycles, with no bubble between passes.
- From the `start` edge, `done` comes `len` + `len`×`passes` + 1 cycles later. This holds when there are no stalls.
- `busy` falls in the cycle after `done`. A new `start` is accepted in that cycle.

## Test plan
- Reset values: hold `rst`=0 for 3 cycles → all outputs 0. `start` pulsed while `rst`=0 → no state change.
- Basic flow: `cfg_len`=4, `cfg_passes`=2, stream 0x0011..0x0044 with `in_valid` held high →
  - writes to addresses 0..3 in 4 cycles;
  - 8 `rd_valid` cycles with data 11,22,33,44,11,22,33,44;
  - `rd_first` on words 0 and 4, `rd_last` on words 3 and 7;
  - `pass_idx` 0,0,0,0,1,1,1,1;
  - `done` coincides with the 8th word.
- Backpressure: gaps in `in_valid` → writes occur only on handshakes. `mac_ready` toggled 1,0,0,1 during READ → no duplicate or skipped words, and `rd_valid` only follows issue cycles.
- Boundaries:
  - `cfg_len`=16, `cfg_passes`=0 → one pass of 16 words; the address wraps to 0 with no 17th word.
  - `cfg_len`=1, `cfg_passes`=3 → three words, each with `rd_first`=`rd_last`=1.
  - `cfg_len`=0 → no activity.
  - `cfg_len`=31 → clamped to 16.
- Reset mid-READ: assert `rst`=0 during pass 1 → next cycle IDLE with all outputs 0. A subsequent `start` runs a full clean sequence.
- Ignored `start`: pulse `start` during LOAD and during READ → no effect on counters, and exactly one `done` is produced.
